// File: rtl/rf_gfx_pkg.sv
// Shared sprite record and scroll FSM encoding for the background scroller.
package rf_gfx_pkg;

  localparam int unsigned COORD_W = 11;

  typedef struct packed {
    logic [COORD_W-1:0] img_id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
  } sprite_state_t;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    ACCEL   = 2'd1,
    CRUISE  = 2'd2,
    DECEL   = 2'd3
  } scroll_fsm_t;

endpackage

// File: rtl/scroll_layer.sv
// One parallax layer: sub-pixel vertical position accumulator with modulo wrap.
module scroll_layer
  import rf_gfx_pkg::*;
#(
  parameter int unsigned SHIFT   = 0,
  parameter int unsigned SPEED_W = 8,
  parameter int unsigned FRAC_W  = 4,
  parameter int unsigned WRAP_Y  = 480
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               frame_start,
  input  logic [SPEED_W-1:0] speed,
  output logic [COORD_W-1:0] y,
  output logic               wrap_pulse
);

  localparam int unsigned POS_W = COORD_W + FRAC_W;
  localparam logic [POS_W-1:0] WRAP_LIM = POS_W'(WRAP_Y << FRAC_W);

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_sum;
  logic [POS_W-1:0] pos_nxt;
  logic             wrap;

  always_comb begin
    pos_sum = pos + POS_W'(speed >> SHIFT);
    wrap    = (pos_sum >= WRAP_LIM);
    pos_nxt = wrap ? (pos_sum - WRAP_LIM) : pos_sum;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos        <= '0;
      wrap_pulse <= 1'b0;
    end else if (frame_start) begin
      pos        <= pos_nxt;
      wrap_pulse <= wrap;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

  assign y = pos[POS_W-1:FRAC_W];

endmodule

// File: rtl/background_scroller.sv
// Multi-layer parallax background: speed ramp FSM, per-layer scroll, odometer.
module background_scroller
  import rf_gfx_pkg::*;
#(
  parameter int unsigned N_LAYERS    = 3,
  parameter int unsigned FRAC_W      = 4,
  parameter int unsigned SPEED_W     = 8,
  parameter int unsigned ACCEL_STEP  = 1,
  parameter int unsigned MAX_SPEED   = 'h40,
  parameter int unsigned WRAP_Y      = 480,
  parameter int unsigned IMG_ID_BASE = 31,
  parameter int unsigned X_POS       = 106,
  parameter int unsigned WIDTH       = 318,
  parameter int unsigned HEIGHT      = 32,
  parameter int unsigned DIST_W      = 16
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               frame_start,
  input  logic                               go,
  input  logic                               stop,
  input  logic [SPEED_W-1:0]                 target_speed,
  output sprite_state_t [N_LAYERS-1:0]       layer_state,
  output logic [SPEED_W-1:0]                 cur_speed,
  output logic [1:0]                         scroll_fsm,
  output logic [N_LAYERS-1:0]                wrap_pulse,
  output logic [DIST_W-1:0]                  distance
);

  localparam logic [SPEED_W-1:0] MAX_SPD = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] STEP    = SPEED_W'(ACCEL_STEP);
  localparam int unsigned        CARRY_W = SPEED_W - FRAC_W + 1;

  scroll_fsm_t        state;
  scroll_fsm_t        state_nxt;
  logic [SPEED_W-1:0] speed_nxt;
  logic [SPEED_W-1:0] tgt;
  logic [SPEED_W-1:0] eff_tgt;
  logic [SPEED_W:0]   up;

  logic [FRAC_W-1:0]  odo_frac;
  logic [SPEED_W:0]   odo_sum;
  logic [CARRY_W-1:0] carry;
  logic [DIST_W:0]    dist_sum;

  // Every move decision steps the speed in the same frame it is taken.
  always_comb begin
    state_nxt = state;
    speed_nxt = cur_speed;
    tgt       = (target_speed > MAX_SPD) ? MAX_SPD : target_speed;
    eff_tgt   = stop ? '0 : tgt;
    up        = (SPEED_W+1)'(cur_speed) + (SPEED_W+1)'(STEP);
    if (state != STOPPED || (go && !stop)) begin
      if (eff_tgt > cur_speed) begin
        speed_nxt = (up >= (SPEED_W+1)'(eff_tgt)) ? eff_tgt : up[SPEED_W-1:0];
        state_nxt = (speed_nxt == eff_tgt) ? CRUISE : ACCEL;
      end else if (eff_tgt < cur_speed) begin
        speed_nxt = ((cur_speed - eff_tgt) <= STEP) ? eff_tgt : (cur_speed - STEP);
        if (speed_nxt == '0) begin
          state_nxt = STOPPED;
        end else if (speed_nxt == eff_tgt) begin
          state_nxt = CRUISE;
        end else begin
          state_nxt = DECEL;
        end
      end else begin
        state_nxt = (cur_speed == '0) ? STOPPED : CRUISE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= STOPPED;
      cur_speed <= '0;
    end else if (frame_start) begin
      state     <= state_nxt;
      cur_speed <= speed_nxt;
    end
  end

  assign scroll_fsm = state;

  // Odometer tracks layer 0's fraction; wrapping removes whole pixels only.
  always_comb begin
    odo_sum  = (SPEED_W+1)'(odo_frac) + (SPEED_W+1)'(cur_speed);
    carry    = odo_sum[SPEED_W:FRAC_W];
    dist_sum = (DIST_W+1)'(distance) + (DIST_W+1)'(carry);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      odo_frac <= '0;
      distance <= '0;
    end else if (frame_start) begin
      odo_frac <= odo_sum[FRAC_W-1:0];
      distance <= dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];
    end
  end

  for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
    logic [COORD_W-1:0] y;

    scroll_layer #(
      .SHIFT   (k),
      .SPEED_W (SPEED_W),
      .FRAC_W  (FRAC_W),
      .WRAP_Y  (WRAP_Y)
    ) u_layer (
      .clk         (clk),
      .resetN      (resetN),
      .frame_start (frame_start),
      .speed       (cur_speed),
      .y           (y),
      .wrap_pulse  (wrap_pulse[k])
    );

    assign layer_state[k] = '{
      img_id: COORD_W'(IMG_ID_BASE + k),
      x:      COORD_W'(X_POS),
      y:      y,
      width:  COORD_W'(WIDTH),
      height: COORD_W'(HEIGHT)
    };
  end

endmodule
